// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: write port, read ports and bulk-clear control/status.
interface regfile_param_if #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 32,
   parameter int NREAD = 2
);
   localparam int AW = $clog2(DEPTH);

   logic                   RegWrite;
   logic [AW-1:0]          WriteRegister;
   logic [WIDTH-1:0]       WriteData;
   logic [NREAD*AW-1:0]    ReadRegister;
   logic [NREAD*WIDTH-1:0] ReadData;
   logic                   clear_req;
   logic                   clear_busy;
   logic                   wr_reject;

   modport master (
      output RegWrite, WriteRegister, WriteData, ReadRegister, clear_req,
      input  ReadData, clear_busy, wr_reject
   );

   modport slave (
      input  RegWrite, WriteRegister, WriteData, ReadRegister, clear_req,
      output ReadData, clear_busy, wr_reject
   );
endinterface

// File: rtl/regfile_param.sv
// DEPTH x WIDTH register file, NREAD combinational read ports, one write port, hardwired-zero entry,
// sequential bulk clear. Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_param #(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 31
) (
   input  logic            clk,
   input  logic            reset,
   regfile_param_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam bit ZERO_EN = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
   localparam logic [AW-1:0] ZERO_IDX = ZERO_EN ? AW'(ZERO_REG) : '0;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                 state, state_nxt;
   logic [AW-1:0]          cnt, cnt_nxt;
   logic [WIDTH-1:0]       regs [DEPTH];
   logic                   busy;
   logic                   reject;
   logic                   wr_en;
   logic [NREAD*WIDTH-1:0] rd_bus;

   function automatic logic is_zero(input logic [AW-1:0] idx);
      return ZERO_EN && (idx == ZERO_IDX);
   endfunction

   assign busy  = (state == CLEAR);
   assign wr_en = bus.RegWrite && !busy && !is_zero(bus.WriteRegister);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (bus.clear_req) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            // Exit on the last entry so the counter never wraps on its own
            if (cnt == LAST_IDX) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         reject <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         reject <= bus.RegWrite && busy;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (busy) begin
         regs[cnt] <= '0;
      end else if (wr_en) begin
         regs[bus.WriteRegister] <= bus.WriteData;
      end
   end

   always_comb begin
      logic [AW-1:0]    ridx;
      logic [WIDTH-1:0] rval;
      rd_bus = '0;
      for (int p = 0; p < NREAD; p++) begin
         ridx = bus.ReadRegister[p*AW +: AW];
         rval = regs[ridx];
         if (is_zero(ridx)) begin
            rval = '0;
`ifdef REGFILE_BYPASS_EN
         end else if (wr_en && (ridx == bus.WriteRegister)) begin
            // wr_en already excludes clear and the zero entry
            rval = bus.WriteData;
`endif
         end
         rd_bus[p*WIDTH +: WIDTH] = rval;
      end
   end

   assign bus.ReadData   = rd_bus;
   assign bus.clear_busy = busy;
   assign bus.wr_reject  = reject;
endmodule
